ysyx_22040931_mem_arbiter: RTL and testbench

//  Shares the single core memory port between instruction fetch (IF, read-only) and data access (MEM, load/store).

---
 rtl/ysyx_22040931_mem_arbiter_pkg.sv | 28 ++
 rtl/ysyx_22040931_arb_grant.sv | 54 +++++
 rtl/ysyx_22040931_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_ysyx_22040931_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040931_mem_arbiter_pkg.sv
// Shared types and defaults for the core memory-port arbiter.
//   arb_state_e  : transaction FSM states (S_IDLE -> S_REQ -> S_RESP -> S_DONE)
//   arb_owner_e  : which requester owns the in-flight transaction
//   pick_word    : selects the 32-bit instruction word out of a 64-bit beat
package ysyx_22040931_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } arb_owner_e;

  localparam int MAX_D_STREAK_DEF = 4;
  localparam int TIMEOUT_DEF      = 255;

  // Instruction words are 4-byte aligned inside an 8-byte beat; addr[2]
  // picks the upper half.
  function automatic logic [31:0] pick_word(input logic [63:0] dword, input logic hi);
    return hi ? dword[63:32] : dword[31:0];
  endfunction

endpackage

// File: rtl/ysyx_22040931_arb_grant.sv
// Grant select with IF forward-progress guarantee.
//   clock, reset   : clock, synchronous active-low reset
//   if_valid       : IF request pending
//   d_valid        : MEM request pending
//   idle           : arbiter can accept a request this cycle
//   handshake      : a request is being accepted this cycle
//   grant          : requester that would be accepted this cycle
// MEM normally wins; after MAX_D_STREAK consecutive MEM grants taken while
// IF was waiting, the next grant goes to IF.
module ysyx_22040931_arb_grant
  import ysyx_22040931_mem_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       if_valid,
  input  logic       d_valid,
  input  logic       idle,
  input  logic       handshake,
  output arb_owner_e grant
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);

  logic [SW-1:0] streak;
  logic          if_turn;

  assign if_turn = if_valid && (streak == SW'(MAX_D_STREAK));

  always_comb begin
    grant = OWNER_IF;
    if (d_valid && !if_turn) grant = OWNER_MEM;
  end

  // The streak only counts MEM wins that actually made IF wait; an idle
  // cycle without an IF request forgets the history.
  always_ff @(posedge clock) begin
    if (!reset) begin
      streak <= '0;
    end else if (idle) begin
      if (!if_valid) begin
        streak <= '0;
      end else if (handshake) begin
        if (grant == OWNER_MEM) begin
          if (streak != SW'(MAX_D_STREAK)) streak <= streak + 1'b1;
        end else begin
          streak <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/ysyx_22040931_mem_arbiter.sv
// Shares the single core memory port between instruction fetch (IF) and
// data access (MEM). One outstanding transaction at a time.
//   clock, reset                      : clock, synchronous active-low reset
//   if_req_valid/ready, if_addr       : IF fetch request
//   if_resp_valid, if_rdata           : IF response pulse + instruction word
//   d_req_valid/ready, d_wr, d_addr,
//   d_wdata, d_wmask                  : MEM load/store request
//   d_resp_valid, d_rdata             : MEM response pulse + load data (0 for stores)
//   m_req_valid/ready, m_wr, m_addr,
//   m_wdata, m_wmask                  : request to the memory interface
//   m_resp_valid, m_rdata             : memory response
//   err                               : one-cycle pulse on timeout abort
//   busy                              : a transaction is in flight
//   dbg_state                         : current FSM state
//
// Handshakes: a request transfers on a cycle where valid and ready are both
// high. Requesters hold valid and their fields stable until ready; the
// arbiter holds m_req_valid and m_* stable until m_req_ready. Responses are
// single-cycle pulses with no back-pressure.
module ysyx_22040931_mem_arbiter
  import ysyx_22040931_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int MAX_D_STREAK = MAX_D_STREAK_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_resp_valid,
  output logic [31:0]       if_rdata,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [7:0]        d_wmask,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [7:0]        m_wmask,
  input  logic              m_resp_valid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_e        state, state_nxt;
  arb_owner_e        owner, grant;
  logic [TW-1:0]     tcnt;
  logic              accept;
  logic              timeout_hit;
  logic              resp_take;
  logic [DATA_W-1:0] rdata_in;

  ysyx_22040931_arb_grant #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_grant (
    .clock     (clock),
    .reset     (reset),
    .if_valid  (if_req_valid),
    .d_valid   (d_req_valid),
    .idle      (state == S_IDLE),
    .handshake (accept),
    .grant     (grant)
  );

  assign accept      = if_req_ready | d_req_ready;
  assign timeout_hit = (TIMEOUT != 0) && (state == S_RESP) && !m_resp_valid &&
                       (tcnt == TW'(TIMEOUT - 1));
  assign resp_take   = (state == S_RESP) && (m_resp_valid || timeout_hit);
  // An aborted transaction reports zero data.
  assign rdata_in    = m_resp_valid ? m_rdata : '0;
  assign dbg_state   = state;

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    if_req_ready = 1'b0;
    d_req_ready  = 1'b0;
    m_req_valid  = 1'b0;
    busy         = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        // Gated by reset so nothing is accepted while reset is held.
        if (reset) begin
          d_req_ready  = (grant == OWNER_MEM);
          if_req_ready = (grant == OWNER_IF) && if_req_valid;
        end
        if (if_req_ready || d_req_ready) state_nxt = S_REQ;
      end
      S_REQ: begin
        m_req_valid = 1'b1;
        if (m_req_ready) state_nxt = S_RESP;
      end
      S_RESP: begin
        if (m_resp_valid)     state_nxt = S_DONE;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      owner         <= OWNER_IF;
      m_wr          <= 1'b0;
      m_addr        <= '0;
      m_wdata       <= '0;
      m_wmask       <= '0;
      tcnt          <= '0;
      if_resp_valid <= 1'b0;
      d_resp_valid  <= 1'b0;
      err           <= 1'b0;
      if_rdata      <= '0;
      d_rdata       <= '0;
    end else begin
      if_resp_valid <= 1'b0;
      d_resp_valid  <= 1'b0;
      err           <= 1'b0;

      if (accept) begin
        owner <= grant;
        if (grant == OWNER_MEM) begin
          m_wr    <= d_wr;
          m_addr  <= d_addr;
          m_wdata <= d_wdata;
          m_wmask <= d_wmask;
        end else begin
          m_wr    <= 1'b0;
          m_addr  <= if_addr;
          m_wdata <= '0;
          m_wmask <= 8'h00;
        end
      end

      if (state == S_REQ && m_req_ready) tcnt <= '0;
      else if (state == S_RESP)          tcnt <= tcnt + 1'b1;

      // Response pulses are registered: they land in S_DONE for a normal
      // completion, or in the first S_IDLE cycle after a timeout abort.
      if (resp_take) begin
        err <= !m_resp_valid;
        if (owner == OWNER_MEM) begin
          d_resp_valid <= 1'b1;
          d_rdata      <= m_wr ? '0 : rdata_in;
        end else begin
          if_resp_valid <= 1'b1;
          if_rdata      <= pick_word(64'(rdata_in), m_addr[2]);
        end
      end
    end
  end

  // A memory response is only meaningful while waiting for one.
  a_resp_in_resp: assert property (@(posedge clock) disable iff (!reset)
                                   m_resp_valid |-> (state == S_RESP));

endmodule

// File: tb/tb_ysyx_22040931_mem_arbiter.sv
module tb_ysyx_22040931_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req_valid, if_req_ready;
  logic [63:0] if_addr;
  logic        if_resp_valid;
  logic [31:0] if_rdata;
  logic        d_req_valid, d_req_ready, d_wr;
  logic [63:0] d_addr, d_wdata;
  logic [7:0]  d_wmask;
  logic        d_resp_valid;
  logic [63:0] d_rdata;
  logic        m_req_valid, m_req_ready, m_wr;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wmask;
  logic        m_resp_valid;
  logic [63:0] m_rdata;
  logic        err, busy;
  logic [1:0]  dbg_state;

  ysyx_22040931_mem_arbiter #(
    .ADDR_W (64), .DATA_W (64), .MAX_D_STREAK (4), .TIMEOUT (8)
  ) dut (
    .clock (clock), .reset (reset),
    .if_req_valid (if_req_valid), .if_req_ready (if_req_ready), .if_addr (if_addr),
    .if_resp_valid (if_resp_valid), .if_rdata (if_rdata),
    .d_req_valid (d_req_valid), .d_req_ready (d_req_ready), .d_wr (d_wr),
    .d_addr (d_addr), .d_wdata (d_wdata), .d_wmask (d_wmask),
    .d_resp_valid (d_resp_valid), .d_rdata (d_rdata),
    .m_req_valid (m_req_valid), .m_req_ready (m_req_ready), .m_wr (m_wr),
    .m_addr (m_addr), .m_wdata (m_wdata), .m_wmask (m_wmask),
    .m_resp_valid (m_resp_valid), .m_rdata (m_rdata),
    .err (err), .busy (busy), .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  // exp entry: {owner_is_d, err, data[63:0]}
  logic [65:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];
  logic        grant_log[$];
  int          n_cmp = 0;
  int          n_mis = 0;

  // memory model configuration
  int          mem_ready_delay = 0;
  int          mem_resp_delay  = 0;
  bit          mem_silent      = 1'b0;
  logic [63:0] mem_rdata       = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void push_exp(input logic owner_d, input logic [63:0] addr, input logic wr);
    logic [63:0] data;
    if (mem_silent)   data = '0;
    else if (owner_d) data = wr ? 64'h0 : mem_rdata;
    else              data = {32'h0, addr[2] ? mem_rdata[63:32] : mem_rdata[31:0]};
    exp_q.push_back({owner_d, mem_silent, data});
    lat_q.push_back(mem_silent ? 10 + mem_ready_delay : 3 + mem_ready_delay + mem_resp_delay);
    acc_q.push_back(cyc);
    grant_log.push_back(owner_d);
  endfunction

  // ---------------- memory model ----------------
  int ph   = 0;
  int mcnt = 0;
  initial begin
    m_req_ready  = 1'b0;
    m_resp_valid = 1'b0;
    m_rdata      = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        m_req_ready = 1'b0; m_resp_valid = 1'b0; ph = 0; mcnt = 0;
      end else begin
        case (ph)
          0: begin
            m_resp_valid = 1'b0;
            m_rdata      = {$urandom, $urandom};
            if (m_req_valid) begin
              if (mcnt >= mem_ready_delay) begin m_req_ready = 1'b1; ph = 1; mcnt = 0; end
              else begin m_req_ready = 1'b0; mcnt++; end
            end else begin
              m_req_ready = 1'b0;
            end
          end
          1: begin
            m_req_ready = 1'b0;
            if (mem_silent) begin
              if (!busy) ph = 0;
            end else if (mcnt >= mem_resp_delay) begin
              m_resp_valid = 1'b1; m_rdata = mem_rdata; ph = 2;
            end else begin
              mcnt++;
            end
          end
          default: begin
            m_resp_valid = 1'b0; m_rdata = {$urandom, $urandom}; ph = 0; mcnt = 0;
          end
        endcase
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [65:0] e;
    int a, l;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (if_req_valid && if_req_ready) push_exp(1'b0, if_addr, 1'b0);
        if (d_req_valid && d_req_ready)   push_exp(1'b1, d_addr, d_wr);
        if (if_resp_valid || d_resp_valid || err) begin
          if (exp_q.size() == 0) begin
            check("unexpected_resp", {if_resp_valid, d_resp_valid, err}, 3'b000);
          end else begin
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            a = acc_q.pop_front();
            check("resp_owner", {d_resp_valid, if_resp_valid}, e[65] ? 2'b10 : 2'b01);
            check("resp_data", e[65] ? d_rdata : {32'h0, if_rdata}, e[63:0]);
            check("resp_err", err, e[64]);
            check("resp_latency", cyc - a, l);
            check("resp_busy", busy, !e[64]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic if_req(input logic [63:0] addr);
    int n = 0;
    if_req_valid = 1'b1;
    if_addr      = addr;
    do begin @(negedge clock); #1; n++; end while (!if_req_ready && n < 200);
    check("if_accept_bound", n < 200, 1'b1);
    @(posedge clock); #1;
    if_req_valid = 1'b0;
  endtask

  task automatic d_req(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] wmask);
    int n = 0;
    d_req_valid = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata; d_wmask = wmask;
    do begin @(negedge clock); #1; n++; end while (!d_req_ready && n < 200);
    check("d_accept_bound", n < 200, 1'b1);
    @(posedge clock); #1;
    d_req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(posedge clock); n++; end
    check("drain_bound", exp_q.size(), 0);
    @(posedge clock); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0, n;
    reset = 1'b0;
    if_req_valid = 1'b0; if_addr = '0;
    d_req_valid = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_m_req_valid", m_req_valid, 1'b0);
    check("rst_resp", {if_resp_valid, d_resp_valid, err}, 3'b000);
    check("rst_m_addr", m_addr, 64'h0);
    check("rst_rdata", {if_rdata, d_rdata}, 96'h0);
    reset = 1'b1;
    @(posedge clock); #1;

    // IF fetch, upper and lower word
    mem_rdata = 64'h11223344_55667788;
    if_req(64'h8000_0004);
    drain(30);
    if_req(64'h8000_0000);
    drain(30);

    // load
    mem_rdata = 64'hDEADBEEF_CAFEF00D;
    d_req(1'b0, 64'h8000_2008, 64'h0, 8'hFF);
    drain(30);

    // store: request fields forwarded exactly
    d_req(1'b1, 64'h8000_1000, 64'hAB, 8'h01);
    check("st_m_req_valid", m_req_valid, 1'b1);
    check("st_m_wr", m_wr, 1'b1);
    check("st_m_addr", m_addr, 64'h8000_1000);
    check("st_m_wdata", m_wdata, 64'hAB);
    check("st_m_wmask", m_wmask, 8'h01);
    drain(30);

    // back-pressure: memory stalls 5 cycles, IF waits behind it
    mem_ready_delay = 5;
    d_req(1'b1, 64'h8000_3000, 64'h01234567_89ABCDEF, 8'hFF);
    if_req_valid = 1'b1; if_addr = 64'h8000_0004;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); #1;
      check("bp_m_req_valid", m_req_valid, 1'b1);
      check("bp_m_addr", m_addr, 64'h8000_3000);
      check("bp_m_wdata", m_wdata, 64'h01234567_89ABCDEF);
      check("bp_if_ready", if_req_ready, 1'b0);
    end
    if_req(64'h8000_0004);
    drain(60);
    mem_ready_delay = 0;

    // contention: both requesters continuously valid
    mem_rdata = 64'hA5A5A5A5_5A5A5A5A;
    n0 = grant_log.size();
    if_addr = 64'h8000_0000;
    d_wr = 1'b0; d_addr = 64'h8000_4000; d_wdata = '0; d_wmask = 8'hFF;
    if_req_valid = 1'b1; d_req_valid = 1'b1;
    n = 0;
    while (grant_log.size() < n0 + 10 && n < 400) begin @(posedge clock); #1; n++; end
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    check("cont_bound", grant_log.size(), n0 + 10);
    for (int i = 0; i < 10; i++)
      if (n0 + i < grant_log.size())
        check("grant_order", grant_log[n0 + i], (i % 5) != 4);
    drain(60);

    // timeout: memory never answers
    mem_silent = 1'b1;
    if_req(64'h8000_0008);
    drain(40);
    check("to_idle", dbg_state, 2'd0);
    mem_silent = 1'b0;

    // random single transactions
    for (int i = 0; i < 6; i++) begin
      mem_ready_delay = $urandom_range(0, 3);
      mem_resp_delay  = $urandom_range(0, 4);
      mem_rdata       = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1)
        d_req(1'($urandom_range(0, 1)), {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFF8)},
              {$urandom, $urandom}, 8'($urandom_range(1, 255)));
      else
        if_req({32'h0, 32'h8000_0000 | (32'($urandom_range(0, 1023)) << 2)});
      drain(60);
    end
    mem_ready_delay = 0;
    mem_resp_delay  = 0;

    // reset in the middle of S_RESP drops the transaction
    mem_silent = 1'b1;
    d_req(1'b0, 64'h8000_5000, 64'h0, 8'hFF);
    n = 0;
    while (dbg_state != 2'd2 && n < 20) begin @(posedge clock); #1; n++; end
    check("mid_resp_reached", dbg_state, 2'd2);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    exp_q.delete(); lat_q.delete(); acc_q.delete();
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_m_req_valid", m_req_valid, 1'b0);
    reset = 1'b1;
    mem_silent = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock); #1;
      check("no_resp_after_reset", {if_resp_valid, d_resp_valid, err}, 3'b000);
    end

    check("final_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
